// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the single-port RAM initiator.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;
  // Cycles from read issue (cen visible) to rsp_valid.
  localparam int unsigned RD_LAT     = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    CLR
  } state_t;

endpackage

// File: rtl/ram_ctrl_rsp_pipe.sv
// Shift register of {valid, last} tracking read issues until their data returns.
module ram_ctrl_rsp_pipe
  import ram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_issue,
  input  logic i_last,
  output logic o_cap,
  output logic o_valid,
  output logic o_last,
  output logic o_busy
);

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_lst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      r_vld <= {r_vld[RD_LAT-2:0], i_issue};
      r_lst <= {r_lst[RD_LAT-2:0], i_last};
    end
  end

  // s_dout holds the issued word one stage before the response is presented.
  assign o_cap   = r_vld[RD_LAT-2];
  assign o_valid = r_vld[RD_LAT-1];
  assign o_last  = r_vld[RD_LAT-1] & r_lst[RD_LAT-1];
  assign o_busy  = |r_vld;

endmodule

// File: rtl/ram_ctrl.sv
// Burst read/write initiator for a single-port RAM (cen/wen/s_addr/s_din/s_dout).
// Optional full-RAM clear engine enabled by defining RAM_CTRL_CLEAR_EN.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout
);

  state_t            r_state;
  state_t            w_nxt_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_nxt_count;
  logic [ADDR_W-1:0] r_s_addr;
  logic [ADDR_W-1:0] w_nxt_s_addr;
  logic [DATA_W-1:0] r_s_din;
  logic [DATA_W-1:0] w_nxt_s_din;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_cen;
  logic              w_nxt_cen;
  logic              r_wen;
  logic              w_nxt_wen;
  logic              r_rd_last;
  logic              w_nxt_rd_last;
  logic              w_req_fire;
  logic              w_pipe_cap;
  logic              w_pipe_valid;
  logic              w_pipe_last;
  logic              w_pipe_busy;

`ifdef RAM_CTRL_CLEAR_EN
  logic r_clr_busy;
  assign req_ready = (r_state == IDLE) && !clr_start;
  assign clr_busy  = r_clr_busy;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_start;
  assign req_ready    = (r_state == IDLE);
  assign clr_busy     = 1'b0;
`endif

  assign w_req_fire = req_valid && req_ready;
  assign wd_ready   = (r_state == WR);
  assign busy       = (r_state != IDLE) || w_pipe_busy;

  // r_addr is always the next address to issue; RAM strobes are computed one cycle ahead.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_addr    = r_addr;
    w_nxt_count   = r_count;
    w_nxt_cen     = 1'b0;
    w_nxt_wen     = 1'b0;
    w_nxt_rd_last = 1'b0;
    w_nxt_s_addr  = r_s_addr;
    w_nxt_s_din   = '0;
    case (r_state)
      IDLE: begin
`ifdef RAM_CTRL_CLEAR_EN
        if (clr_start) begin
          w_nxt_state  = CLR;
          w_nxt_cen    = 1'b1;
          w_nxt_wen    = 1'b1;
          w_nxt_s_addr = '0;
          w_nxt_addr   = ADDR_W'(1);
          w_nxt_count  = '1;
        end else
`endif
        if (w_req_fire) begin
          w_nxt_count = req_len;
          if (req_wr) begin
            w_nxt_state = WR;
            w_nxt_addr  = req_addr;
          end else begin
            w_nxt_state   = RD;
            w_nxt_cen     = 1'b1;
            w_nxt_s_addr  = req_addr;
            w_nxt_addr    = req_addr + ADDR_W'(1);
            w_nxt_rd_last = (req_len == '0);
          end
        end
      end
      RD: begin
        if (r_count == '0) begin
          w_nxt_state = DRAIN;
        end else begin
          w_nxt_cen     = 1'b1;
          w_nxt_s_addr  = r_addr;
          w_nxt_addr    = r_addr + ADDR_W'(1);
          w_nxt_count   = r_count - ADDR_W'(1);
          w_nxt_rd_last = (r_count == ADDR_W'(1));
        end
      end
      DRAIN: begin
        if (w_pipe_last) begin
          w_nxt_state = IDLE;
        end
      end
      WR: begin
        if (wd_valid) begin
          w_nxt_cen    = 1'b1;
          w_nxt_wen    = 1'b1;
          w_nxt_s_addr = r_addr;
          w_nxt_s_din  = wd_data;
          w_nxt_addr   = r_addr + ADDR_W'(1);
          if (r_count == '0) begin
            w_nxt_state = IDLE;
          end else begin
            w_nxt_count = r_count - ADDR_W'(1);
          end
        end
      end
`ifdef RAM_CTRL_CLEAR_EN
      CLR: begin
        if (r_count == '0) begin
          w_nxt_state = IDLE;
        end else begin
          w_nxt_cen    = 1'b1;
          w_nxt_wen    = 1'b1;
          w_nxt_s_addr = r_addr;
          w_nxt_addr   = r_addr + ADDR_W'(1);
          w_nxt_count  = r_count - ADDR_W'(1);
        end
      end
`endif
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_cen      <= 1'b0;
      r_wen      <= 1'b0;
      r_rd_last  <= 1'b0;
      r_s_addr   <= '0;
      r_s_din    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_addr    <= w_nxt_addr;
      r_count   <= w_nxt_count;
      r_cen     <= w_nxt_cen;
      r_wen     <= w_nxt_wen;
      r_rd_last <= w_nxt_rd_last;
      r_s_addr  <= w_nxt_s_addr;
      r_s_din   <= w_nxt_s_din;
      if (w_pipe_cap) begin
        r_rsp_data <= s_dout;
      end
    end
  end

`ifdef RAM_CTRL_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_busy <= 1'b0;
    end else begin
      r_clr_busy <= (w_nxt_state == CLR);
    end
  end
`endif

  ram_ctrl_rsp_pipe u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_issue (r_cen & ~r_wen),
    .i_last  (r_rd_last),
    .o_cap   (w_pipe_cap),
    .o_valid (w_pipe_valid),
    .o_last  (w_pipe_last),
    .o_busy  (w_pipe_busy)
  );

  assign cen       = r_cen;
  assign wen       = r_wen;
  assign s_addr    = r_s_addr;
  assign s_din     = r_s_din;
  assign rsp_valid = w_pipe_valid;
  assign rsp_last  = w_pipe_last;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural RAM, shadow memory model, directed and random bursts.
module tb_ram_ctrl;

  typedef struct packed { logic [7:0] addr; logic [63:0] data; } wr_t;
  typedef struct packed { logic [63:0] data; logic last; int cyc; } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [7:0]  req_addr, req_len;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic        rsp_valid, rsp_last, busy, clr_start, clr_busy, cen, wen;
  logic [63:0] rsp_data, s_din, s_dout;
  logic [7:0]  s_addr;

  logic [63:0] ram       [256];
  logic [63:0] model_mem [256];
  wr_t         exp_wr[$];
  int          wr_cyc_q[$];
  rsp_t        rsp_log[$];
  logic [63:0] wq_data[$];
  int          wq_stall[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          n_unexp = 0;
  wr_t         mon_e;

  ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .clr_start(clr_start), .clr_busy(clr_busy),
    .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (cen) begin
      if (wen) ram[s_addr] <= s_din;
      else     s_dout      <= ram[s_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: RAM writes against expected queue, read responses logged with cycle stamps.
  always @(negedge clk) begin
    if (rst_n && cen && wen) begin
      if (exp_wr.size() == 0) begin
        n_unexp++;
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", 64'(s_addr), 64'(mon_e.addr));
        chk("wr_data", s_din, mon_e.data);
      end
      wr_cyc_q.push_back(cyc);
    end
    if (rst_n && rsp_valid) rsp_log.push_back({rsp_data, rsp_last, cyc});
  end

  task automatic issue_req(input bit wr, input logic [7:0] a, input logic [7:0] len,
                           output int hs);
    bit ok;
    ok = 1'b0;
    hs = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = len;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      ok = req_ready;
      if (ok) hs = cyc;
      @(posedge clk); #1;
      if (ok) break;
    end
    req_valid = 1'b0;
    if (!ok) chk("req_timeout", 64'(ok), 64'd1);
  endtask

  task automatic collect_rsp(input logic [7:0] a, input int n, input int hs);
    int m;
    logic [7:0] ad;
    for (int t = 0; t < n + 20; t++) begin
      @(posedge clk);
      if (rsp_log.size() >= n) break;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rd_beats", 64'(rsp_log.size()), 64'(n));
    m = (rsp_log.size() < n) ? rsp_log.size() : n;
    for (int i = 0; i < m; i++) begin
      ad = a + 8'(i);
      chk("rd_data", rsp_log[i].data, model_mem[ad]);
      chk("rd_last", 64'(rsp_log[i].last), 64'(i == n - 1));
      chk("rd_cycle", 64'(rsp_log[i].cyc), 64'(hs + 3 + i));
    end
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    int hs;
    rsp_log.delete();
    issue_req(1'b0, a, 8'(n - 1), hs);
    collect_rsp(a, n, hs);
  endtask

  // Sends wq_data with wq_stall idle cycles before each beat; optional immediate readback.
  task automatic do_write(input logic [7:0] a, input bit b2b);
    int n, hs, span;
    bit ok;
    logic [7:0] ad;
    n = wq_data.size();
    span = n - 1;
    for (int i = 0; i < n; i++) begin
      ad = a + 8'(i);
      exp_wr.push_back({ad, wq_data[i]});
      model_mem[ad] = wq_data[i];
      if (i > 0) span += wq_stall[i];
    end
    wr_cyc_q.delete();
    issue_req(1'b1, a, 8'(n - 1), hs);
    for (int i = 0; i < n; i++) begin
      wd_valid = 1'b0;
      repeat (wq_stall[i]) begin @(posedge clk); #1; end
      wd_valid = 1'b1;
      wd_data  = wq_data[i];
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        ok = wd_ready;
        @(posedge clk); #1;
        if (ok) break;
      end
      if (!ok) chk("wd_timeout", 64'(ok), 64'd1);
    end
    wd_valid = 1'b0;
    wd_data  = '0;
    chk("wr_final_in_idle", 64'({cen, wen, req_ready, wd_ready}), 64'(4'b1110));
    if (b2b) do_read(a, n);
    else repeat (3) @(posedge clk);
    #1;
    chk("wr_count", 64'(wr_cyc_q.size()), 64'(n));
    if (wr_cyc_q.size() == n) chk("wr_span", 64'(wr_cyc_q[n-1] - wr_cyc_q[0]), 64'(span));
  endtask

  task automatic load_beats(input int n);
    wq_data.delete();
    wq_stall.delete();
    for (int i = 0; i < n; i++) begin
      wq_data.push_back({$urandom, $urandom});
      wq_stall.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, n;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; model_mem[i] = '0; end
    s_dout = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 64'({cen, wen, rsp_valid, rsp_last, busy, clr_busy, wd_ready}), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    chk("rst_din", s_din, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat write then immediate readback.
    wq_data = '{64'hDEADBEEF}; wq_stall = '{0};
    do_write(8'h10, 1'b1);

    // Wrapping 4-beat burst.
    wq_data = '{64'd1, 64'd2, 64'd3, 64'd4}; wq_stall = '{0, 0, 0, 0};
    do_write(8'hFE, 1'b1);

    // Two idle cycles mid-burst.
    wq_data = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66};
    wq_stall = '{0, 0, 0, 2, 0, 0};
    do_write(8'h40, 1'b0);
    do_read(8'h40, 6);

    // Reset in the middle of a 16-beat read.
    load_beats(16);
    do_write(8'h20, 1'b0);
    rsp_log.delete();
    issue_req(1'b0, 8'h20, 8'd15, hs);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pre_rsp", 64'(rsp_log.size()), 64'd2);
    chk("rst_mid_ctl", 64'({cen, wen, rsp_valid, rsp_last, busy, clr_busy}), 64'd0);
    chk("rst_mid_addr", 64'(s_addr), 64'd0);
    chk("rst_mid_data", rsp_data, 64'd0);
    @(posedge clk); #1;
    rsp_log.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_rsp", 64'(rsp_log.size()), 64'd0);
    chk("rst_idle", 64'({req_ready, busy}), 64'(2'b10));

    // Clear request racing a read request.
    wq_data = '{64'hFFFF_FFFF_FFFF_FFFF}; wq_stall = '{0};
    do_write(8'h80, 1'b0);
    rsp_log.delete();
`ifdef RAM_CTRL_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      exp_wr.push_back({8'(i), 64'd0});
      model_mem[i] = '0;
    end
    clr_start = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h80; req_len = 8'd0;
    @(negedge clk);
    chk("clr_req_blocked", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(negedge clk);
    chk("clr_busy_on", 64'({clr_busy, req_ready}), 64'(2'b10));
    @(posedge clk); #1;
    issue_req(1'b0, 8'h80, 8'd0, hs);
    chk("clr_writes_left", 64'(exp_wr.size()), 64'd0);
    chk("clr_busy_off", 64'(clr_busy), 64'd0);
    collect_rsp(8'h80, 1, hs);
`else
    clr_start = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h80; req_len = 8'd0;
    @(negedge clk);
    chk("noclr_req_ready", 64'(req_ready), 64'd1);
    chk("noclr_busy", 64'(clr_busy), 64'd0);
    hs = cyc;
    @(posedge clk); #1;
    clr_start = 1'b0;
    req_valid = 1'b0;
    collect_rsp(8'h80, 1, hs);
    chk("noclr_busy_after", 64'(clr_busy), 64'd0);
`endif

    // Randomized bursts.
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom);
      n = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) begin
        load_beats(n);
        do_write(a, 1'($urandom_range(0, 1)));
      end else begin
        do_read(a, n);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("exp_wr_left", 64'(exp_wr.size()), 64'd0);
    chk("wr_unexpected", 64'(n_unexp), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
